week6_parity_serial_tx: RTL

- Serial frame transmitter. Parity is generated by XOR reduction of the data word.
- Accepts a parallel word through a valid/ready handshake and shifts it out on one line: start bit, data LSB first, parity bit, stop bit.
- Pairs with the week-6 serial parity receiver/checker, which is the other end of the same line protocol.
- Sits between the exercise stimulus logic and the serial pin.

---
 rtl/week6_parity_serial_tx_if.sv | 14 +
 rtl/week6_parity_serial_tx.sv | 114 +++++++++++
 2 files changed

// File: rtl/week6_parity_serial_tx_if.sv
// Handshake and serial-line bundle for the week-6 parity frame transmitter.
interface week6_parity_serial_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic              valid_in;
  logic              ready_out;
  logic              tx;
  logic              busy;
  logic              done;

  modport master (output data_in, valid_in, input ready_out, tx, busy, done);
  modport slave  (input data_in, valid_in, output ready_out, tx, busy, done);
endinterface

// File: rtl/week6_parity_serial_tx.sv
// Serial frame transmitter: start bit, data LSB first, parity bit, stop bit.
// Accepts one word per frame in IDLE only; tx is registered, done/ready/busy are state-decoded.
module week6_parity_serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int ODD_PARITY   = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  week6_parity_serial_tx_if.slave   bus
);
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_W + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]        r_state;
  logic [BAUD_W-1:0] r_baud;
  logic [BIT_W-1:0]  r_bitcnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_parity;
  logic              r_tx;

  logic              w_bit_end;
  logic [BIT_W-1:0]  w_bitcnt_nxt;
  logic [DATA_W-1:0] w_shift_nxt;

  assign w_bit_end    = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
  assign w_bitcnt_nxt = r_bitcnt + BIT_W'(1);
  assign w_shift_nxt  = r_shift >> 1;

  assign bus.tx        = r_tx;
  assign bus.ready_out = (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_STOP) && w_bit_end;

  // tx is loaded one cycle ahead of each bit so the line changes exactly on bit boundaries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_tx     <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx   <= 1'b1;
          r_baud <= '0;
          if (bus.valid_in) begin
            r_shift  <= bus.data_in;
            r_parity <= (^bus.data_in) ^ 1'(ODD_PARITY);
            r_bitcnt <= '0;
            r_tx     <= 1'b0;
            r_state  <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (w_bitcnt_nxt == BIT_W'(DATA_W)) begin
              r_bitcnt <= '0;
              r_tx     <= r_parity;
              r_state  <= S_PARITY;
            end else begin
              r_bitcnt <= w_bitcnt_nxt;
              r_shift  <= w_shift_nxt;
              r_tx     <= w_shift_nxt[0];
            end
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_tx    <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_baud  <= '0;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end
endmodule
